// File: rtl/debug_pager_display.sv
// Debugger display controller: pages a peeked register or memory word onto
// four hex digits and shows the current line number (PC / 4) as two decimal
// digits produced by a multi-cycle double-dabble converter.
module debug_pager_display #(
  parameter int DATA_W      = 32,
  parameter int AUTO_PERIOD = 0,
  parameter int LINE_MAX    = 99,
  localparam int NPAGES     = DATA_W / 16,
  localparam int PAGE_W     = (NPAGES > 1) ? $clog2(NPAGES) : 1
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [9:0]        switches,
  input  logic              pageBtn,
  input  logic [DATA_W-1:0] regData,
  input  logic [DATA_W-1:0] memData,
  input  logic [31:0]       address,
  output logic [4:0]        regToPeek,
  output logic [31:0]       memToPeek,
  output logic [3:0]        ss0,
  output logic [3:0]        ss1,
  output logic [3:0]        ss2,
  output logic [3:0]        ss3,
  output logic [3:0]        ss4,
  output logic [3:0]        ss5,
  output logic [PAGE_W-1:0] page,
  output logic              bcdBusy
);

  localparam int TIMER_W = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
  localparam bit AUTO_EN = (AUTO_PERIOD > 0);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'((AUTO_PERIOD > 0) ? AUTO_PERIOD - 1 : 0);
  localparam logic [PAGE_W-1:0]  PAGE_LAST  = PAGE_W'(NPAGES - 1);
  localparam logic [6:0]         LINE_SAT   = 7'(LINE_MAX);
  localparam logic [2:0]         LAST_ITER  = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CONV,
    ST_WRITE
  } conv_state_e;

  // Paging state
  logic               btn_prev_q, btn_prev_d;
  logic               last_src_q, last_src_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [PAGE_W-1:0]  page_q, page_d;
  logic               btn_edge;
  logic               timer_expire;
  logic               src_change;
  logic               advance;

  // Peek and hex display state
  logic [4:0]         reg_to_peek_q, reg_to_peek_d;
  logic [31:0]        mem_to_peek_q, mem_to_peek_d;
  logic [15:0]        disp_q, disp_d;
  logic [DATA_W-1:0]  sel_word;

  // Line number conversion state
  conv_state_e        state_q, state_d;
  logic [31:0]        last_addr_q, last_addr_d;
  logic [6:0]         v_q, v_d;
  logic [7:0]         bcd_q, bcd_d;
  logic [2:0]         cnt_q, cnt_d;
  logic [3:0]         ss4_q, ss4_d;
  logic [3:0]         ss5_q, ss5_d;
  logic               busy_q, busy_d;
  logic               addr_changed;
  logic [6:0]         line_sat;
  logic [7:0]         dd_adj;
  logic [7:0]         dd_bcd_next;
  logic [6:0]         dd_v_next;

  // Page selection: button rising edge or auto timer advances, a source flip restarts at page 0
  always_comb begin
    btn_edge     = pageBtn & ~btn_prev_q;
    timer_expire = AUTO_EN && (timer_q == TIMER_LAST);
    src_change   = (switches[9] != last_src_q);
    advance      = btn_edge | timer_expire;
    btn_prev_d   = pageBtn;
    last_src_d   = switches[9];
    timer_d      = timer_q;
    page_d       = page_q;
    if (!AUTO_EN) begin
      timer_d = '0;
    end else if (src_change || btn_edge || timer_expire) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q + 1'b1;
    end
    if (src_change) begin
      page_d = '0;
    end else if (advance) begin
      page_d = (page_q == PAGE_LAST) ? '0 : page_q + 1'b1;
    end
  end

  // Paging registers
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      btn_prev_q <= 1'b0;
      last_src_q <= 1'b0;
      timer_q    <= '0;
      page_q     <= '0;
    end else begin
      btn_prev_q <= btn_prev_d;
      last_src_q <= last_src_d;
      timer_q    <= timer_d;
      page_q     <= page_d;
    end
  end

  // Forward the switch selections to the peek ports and pick the 16-bit slice shown on ss0..ss3
  always_comb begin
    reg_to_peek_d = switches[4:0];
    mem_to_peek_d = {23'b0, switches[8:0]};
    sel_word      = switches[9] ? memData : regData;
    disp_d        = sel_word[{page_q, 4'b0000} +: 16];
  end

  // Peek and hex display registers
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      reg_to_peek_q <= '0;
      mem_to_peek_q <= '0;
      disp_q        <= '0;
    end else begin
      reg_to_peek_q <= reg_to_peek_d;
      mem_to_peek_q <= mem_to_peek_d;
      disp_q        <= disp_d;
    end
  end

  // One double-dabble step: add 3 to any BCD digit of 5 or more, then shift {bcd, v} left
  always_comb begin
    dd_adj[3:0] = (bcd_q[3:0] >= 4'd5) ? bcd_q[3:0] + 4'd3 : bcd_q[3:0];
    dd_adj[7:4] = (bcd_q[7:4] >= 4'd5) ? bcd_q[7:4] + 4'd3 : bcd_q[7:4];
    dd_bcd_next = {dd_adj[6:0], v_q[6]};
    dd_v_next   = {v_q[5:0], 1'b0};
    line_sat    = (address[31:2] > 30'(LINE_MAX)) ? LINE_SAT : address[8:2];
  end

  // Line conversion FSM: latch a new address, iterate seven times, then publish both digits at once
  always_comb begin
    state_d      = state_q;
    last_addr_d  = last_addr_q;
    v_d          = v_q;
    bcd_d        = bcd_q;
    cnt_d        = cnt_q;
    ss4_d        = ss4_q;
    ss5_d        = ss5_q;
    addr_changed = (address != last_addr_q);
    case (state_q)
      ST_IDLE: begin
        if (addr_changed) begin
          last_addr_d = address;
          v_d         = line_sat;
          bcd_d       = '0;
          cnt_d       = '0;
          state_d     = ST_CONV;
        end
      end
      ST_CONV: begin
        if (addr_changed) begin
          last_addr_d = address;
          v_d         = line_sat;
          bcd_d       = '0;
          cnt_d       = '0;
        end else begin
          bcd_d = dd_bcd_next;
          v_d   = dd_v_next;
          if (cnt_q == LAST_ITER) begin
            state_d = ST_WRITE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_WRITE: begin
        ss4_d   = bcd_q[3:0];
        ss5_d   = bcd_q[7:4];
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // Line conversion registers
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q     <= ST_IDLE;
      last_addr_q <= '0;
      v_q         <= '0;
      bcd_q       <= '0;
      cnt_q       <= '0;
      ss4_q       <= '0;
      ss5_q       <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_addr_q <= last_addr_d;
      v_q         <= v_d;
      bcd_q       <= bcd_d;
      cnt_q       <= cnt_d;
      ss4_q       <= ss4_d;
      ss5_q       <= ss5_d;
      busy_q      <= busy_d;
    end
  end

  assign regToPeek = reg_to_peek_q;
  assign memToPeek = mem_to_peek_q;
  assign ss0       = disp_q[3:0];
  assign ss1       = disp_q[7:4];
  assign ss2       = disp_q[11:8];
  assign ss3       = disp_q[15:12];
  assign ss4       = ss4_q;
  assign ss5       = ss5_q;
  assign page      = page_q;
  assign bcdBusy   = busy_q;

endmodule
